// File: rtl/lane_pkg.sv
// lane_pkg: shared constants, state type and LFSR helper for the lane blocks.
`timescale 1ns/1ps
package lane_pkg;

    localparam int          LANE_WIDTH = 16;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic {
        ACTIVE = 1'b0,
        DEAD   = 1'b1
    } lane_state_t;

    // One right-shifting Galois step: feedback bit 0 is XORed into the tap positions.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lane_spawn_lfsr.sv
// lane_spawn_lfsr: tick counter, car-step pulse, traffic LFSR and spawn decision.
// Ports:
//   clk, reset (async active-low)
//   enable      game running
//   speed[7:0]  cycles per car step, 0 freezes
//   run         lane is ACTIVE
//   gl[1:0]     two lowest car cells, used for the gap rule
//   step        combinational pulse in the cycle the cars advance
//   spawn       a new car enters cell 0 on this step
`timescale 1ns/1ps
module lane_spawn_lfsr
    import lane_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] speed,
    input  logic       run,
    input  logic [1:0] gl,
    output logic       step,
    output logic       spawn
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [7:0]  cnt_r;
    logic [15:0] lfsr_r;
    logic        count_en_s;
    logic        step_s;

    // Step when the count reaches speed-1; >= tolerates speed dropping mid-count.
    always_comb begin
        count_en_s = enable & (speed != 8'd0) & run;
        step_s     = reset & count_en_s & (cnt_r >= (speed - 8'd1));
    end

    assign step  = step_s;
    // Require two empty cells behind the last car so the lane stays crossable.
    assign spawn = (lfsr_r[1:0] == 2'b00) & ~gl[0] & ~gl[1];

    // Tick counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 8'd0;
        end else if (step_s) begin
            cnt_r <= 8'd0;
        end else if (count_en_s) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Traffic LFSR advances once per car step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_r <= SEED_EFF;
        end else if (step_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

endmodule

// File: rtl/lane_left.sv
// lane_left: leftward (toward MSB) traffic lane with player tracking and collision.
// Ports:
//   clk, reset (async active-low)
//   enable                 game running
//   up, down, left, right  one-cycle move pulses
//   fabove, fbelow         player position in neighbouring lanes (one-hot or 0)
//   speed[7:0]             cycles per car step, 0 freezes cars
//   rl                     player position in this lane (one-hot or 0)
//   gl                     car lights
//   step                   combinational pulse in the cycle the cars advance
//   lose                   sticky collision flag
`timescale 1ns/1ps
module lane_left
    import lane_pkg::*;
#(
    parameter int          WIDTH = LANE_WIDTH,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic [WIDTH-1:0] fabove,
    input  logic [WIDTH-1:0] fbelow,
    input  logic [7:0]       speed,
    output logic [WIDTH-1:0] rl,
    output logic [WIDTH-1:0] gl,
    output logic             step,
    output logic             lose
);

    lane_state_t      state_r, state_n;
    logic [WIDTH-1:0] rl_r, rl_n;
    logic [WIDTH-1:0] gl_r, gl_n;
    logic             lose_r, lose_n;
    logic             step_s, spawn_s, run_s, hit_s;

    assign run_s = (state_r == ACTIVE);

    lane_spawn_lfsr #(.SEED(SEED)) u_spawn (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .speed  (speed),
        .run    (run_s),
        .gl     (gl_r[1:0]),
        .step   (step_s),
        .spawn  (spawn_s)
    );

    // Next-state: car shift, collision, and prioritised player moves.
    always_comb begin
        state_n = state_r;
        rl_n    = rl_r;
        gl_n    = gl_r;
        lose_n  = lose_r;
        hit_s   = |(rl_r & gl_r);
        case (state_r)
            ACTIVE: begin
                // Cars and player both commit in the same cycle; an overlap
                // they create is seen on the registered values next cycle.
                if (step_s) begin
                    gl_n = {gl_r[WIDTH-2:0], spawn_s};
                end else begin
                    gl_n = gl_r;
                end
                // Collision is checked even while paused.
                if (hit_s) begin
                    state_n = DEAD;
                    lose_n  = 1'b1;
                end else if (enable) begin
                    if ((left & right) | (left & rl_r[WIDTH-1]) | (right & rl_r[0])) begin
                        rl_n = rl_r;
                    end else if (left) begin
                        rl_n = {rl_r[WIDTH-2:0], 1'b0};
                    end else if (right) begin
                        rl_n = {1'b0, rl_r[WIDTH-1:1]};
                    end else if (up & (fbelow != '0)) begin
                        rl_n = fbelow;
                    end else if (down & (fabove != '0)) begin
                        rl_n = fabove;
                    end else if ((up | down) & (rl_r != '0)) begin
                        rl_n = '0;
                    end else begin
                        rl_n = rl_r;
                    end
                end else begin
                    rl_n = rl_r;
                end
            end
            DEAD: begin
                state_n = DEAD;
                lose_n  = 1'b1;
            end
            default: begin
                state_n = DEAD;
                lose_n  = 1'b1;
            end
        endcase
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ACTIVE;
            rl_r    <= '0;
            gl_r    <= '0;
            lose_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            rl_r    <= rl_n;
            gl_r    <= gl_n;
            lose_r  <= lose_n;
        end
    end

    assign rl   = rl_r;
    assign gl   = gl_r;
    assign lose = lose_r;
    assign step = step_s;

endmodule
